// File: rtl/line_window_reader_pkg.sv
// Shared defaults, FSM encoding and window indexing for the line window reader.
package line_window_reader_pkg;

    localparam int NUM_LINE_DEF = 5;
    localparam int PWIDTH_DEF   = 14;
    localparam int AWIDTH_DEF   = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Flat element index of window element [r][c] (c = 0 is the oldest column).
    function automatic int elem_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/line_window_reader_shift.sv
// NUM_LINE-deep column shift register; exposes the full window in parallel.
module window_shift_reg
    import line_window_reader_pkg::*;
#(
    parameter int NUM_LINE = NUM_LINE_DEF,
    parameter int PWIDTH   = PWIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_en,
    input  logic [NUM_LINE*PWIDTH-1:0]          i_col,
    output logic [NUM_LINE*NUM_LINE*PWIDTH-1:0] o_win
);

    // Index 0 is the oldest column, NUM_LINE-1 the newest.
    logic [NUM_LINE-1:0][NUM_LINE*PWIDTH-1:0] r_cols;

    // Shift the newest column in at the top on each enabled column.
    always_ff @(posedge clk) begin
        if (rst)
            r_cols <= '0;
        else if (i_en)
            r_cols <= {i_col, r_cols[NUM_LINE-1:1]};
    end

    // Re-arrange column-major storage into the row-major window layout.
    for (genvar gr = 0; gr < NUM_LINE; gr++) begin : g_row
        for (genvar gc = 0; gc < NUM_LINE; gc++) begin : g_col
            localparam int IDX = elem_idx(gr, gc, NUM_LINE);
            assign o_win[IDX*PWIDTH +: PWIDTH] = r_cols[gc][gr*PWIDTH +: PWIDTH];
        end
    end

endmodule

// File: rtl/line_window_reader.sv
// Builds NUM_LINE x NUM_LINE interior windows from line-buffer columns.
module line_window_reader
    import line_window_reader_pkg::*;
#(
    parameter int NUM_LINE = NUM_LINE_DEF,
    parameter int PWIDTH   = PWIDTH_DEF,
    parameter int AWIDTH   = AWIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clken,
    input  logic                                start,
    input  logic [AWIDTH-1:0]                   width,
    input  logic [AWIDTH-1:0]                   height,
    input  logic                                in_valid,
    input  logic [NUM_LINE*PWIDTH-1:0]          col_data,
    input  logic [NUM_LINE-1:0]                 line_valid,
    output logic                                win_valid,
    output logic [NUM_LINE*NUM_LINE*PWIDTH-1:0] win_data,
    output logic [AWIDTH-1:0]                   win_x,
    output logic [AWIDTH-1:0]                   win_y,
    output logic                                frame_done,
    output logic                                err,
    output logic                                busy
);

    localparam logic [AWIDTH-1:0] C_MIN       = AWIDTH'(NUM_LINE);
    localparam logic [AWIDTH-1:0] C_EDGE      = AWIDTH'(NUM_LINE - 1);
    localparam logic [AWIDTH-1:0] C_LAST_FILL = AWIDTH'(NUM_LINE - 2);
    localparam logic [AWIDTH-1:0] C_HALF      = AWIDTH'((NUM_LINE - 1) / 2);

    state_t            r_state, w_state_nxt;
    logic [AWIDTH-1:0] r_width, r_height, r_col_cnt, r_row_cnt;
    logic [AWIDTH-1:0] r_win_x, r_win_y;
    logic              r_win_valid, r_err;

    logic w_accept, w_start, w_dims_ok, w_col_last, w_row_last, w_win_hit;

    assign w_accept   = clken && in_valid && (r_state == S_FILL || r_state == S_RUN);
    assign w_start    = clken && start && (r_state == S_IDLE);
    assign w_dims_ok  = (width >= C_MIN) && (height >= C_MIN);
    assign w_col_last = (r_col_cnt == r_width - AWIDTH'(1));
    assign w_row_last = (r_row_cnt == r_height - AWIDTH'(1));
    // Column gating keeps leftovers from the previous row out of any window.
    assign w_win_hit  = w_accept && (r_col_cnt >= C_EDGE) && (r_row_cnt >= C_EDGE);

    // State register; frozen while clken is low.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else if (clken)
            r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start && w_dims_ok) w_state_nxt = S_FILL;
            S_FILL: if (w_accept && w_col_last && r_row_cnt == C_LAST_FILL) w_state_nxt = S_RUN;
            S_RUN:  if (w_accept && w_col_last && w_row_last) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame geometry, counters, error flag and window coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_width     <= '0;
            r_height    <= '0;
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            r_win_x     <= '0;
            r_win_y     <= '0;
            r_win_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (clken) begin
            if (w_start) begin
                if (w_dims_ok) begin
                    r_width   <= width;
                    r_height  <= height;
                    r_col_cnt <= '0;
                    r_row_cnt <= '0;
                    r_err     <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_accept) begin
                if (w_col_last) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= r_row_cnt + AWIDTH'(1);
                end else begin
                    r_col_cnt <= r_col_cnt + AWIDTH'(1);
                end
                if (r_state == S_RUN && line_valid != {NUM_LINE{1'b1}})
                    r_err <= 1'b1;
            end
            r_win_valid <= w_win_hit;
            if (w_win_hit) begin
                r_win_x <= r_col_cnt - C_HALF;
                r_win_y <= r_row_cnt - C_HALF;
            end
        end
    end

    window_shift_reg #(
        .NUM_LINE (NUM_LINE),
        .PWIDTH   (PWIDTH)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_accept),
        .i_col (col_data),
        .o_win (win_data)
    );

    assign win_valid  = r_win_valid;
    assign win_x      = r_win_x;
    assign win_y      = r_win_y;
    assign err        = r_err;
    assign frame_done = (r_state == S_DONE);
    assign busy       = (r_state == S_FILL) || (r_state == S_RUN);

endmodule

// File: tb/tb_line_window_reader.sv
// Directed bench for line_window_reader with a window scoreboard.
module tb_line_window_reader;

    localparam int NL = 5;
    localparam int PW = 14;
    localparam int AW = 11;
    localparam int DW = NL * NL * PW;

    logic              clk = 1'b0;
    logic              rst, clken, start, in_valid;
    logic [AW-1:0]     width, height;
    logic [NL*PW-1:0]  col_data;
    logic [NL-1:0]     line_valid;
    logic              win_valid, frame_done, err, busy;
    logic [DW-1:0]     win_data;
    logic [AW-1:0]     win_x, win_y;

    line_window_reader #(.NUM_LINE(NL), .PWIDTH(PW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .clken(clken), .start(start),
        .width(width), .height(height), .in_valid(in_valid),
        .col_data(col_data), .line_valid(line_valid),
        .win_valid(win_valid), .win_data(win_data), .win_x(win_x), .win_y(win_y),
        .frame_done(frame_done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] x;
        logic [AW-1:0] y;
        logic [DW-1:0] data;
    } win_t;

    win_t        sb[$];
    win_t        last_exp, mon_e;
    int          errors = 0, checks = 0;
    int          win_cnt = 0, fd_cnt = 0;
    bit          got_first = 0;
    logic [AW-1:0] f_x, f_y;
    logic [PW-1:0] f_00, f_44;
    logic        mon_en;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int base, input int r, input int c);
        if (r < 0) return PW'(14'h3000 | c);
        return PW'(base + r * 16 + c);
    endfunction

    // Monitor: samples just after each rising edge.
    always begin
        @(posedge clk);
        mon_en = clken;
        #1;
        if (mon_en) begin
            if (frame_done) fd_cnt++;
            if (win_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_win", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("win_x", win_x, mon_e.x);
                    chk("win_y", win_y, mon_e.y);
                    chk("win_data", win_data, mon_e.data);
                    last_exp = mon_e;
                    if (!got_first) begin
                        got_first = 1;
                        f_x  = win_x;
                        f_y  = win_y;
                        f_00 = win_data[0 +: PW];
                        f_44 = win_data[(4*NL+4)*PW +: PW];
                    end
                    win_cnt++;
                end
            end
        end else if (win_valid) begin
            chk("hold_data", win_data, last_exp.data);
            chk("hold_x", win_x, last_exp.x);
        end
    end

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        start = 1; width = AW'(w); height = AW'(h);
        @(negedge clk);
        start = 0;
    endtask

    task automatic send_col(input int base, input int r, input int c, input logic [NL-1:0] lv);
        win_t e;
        @(negedge clk);
        in_valid   = 1;
        line_valid = lv;
        for (int k = 0; k < NL; k++) col_data[k*PW +: PW] = pix(base, r - (NL-1) + k, c);
        if (r >= NL-1 && c >= NL-1) begin
            e.x = AW'(c - (NL-1)/2);
            e.y = AW'(r - (NL-1)/2);
            for (int wr = 0; wr < NL; wr++)
                for (int wc = 0; wc < NL; wc++)
                    e.data[(wr*NL+wc)*PW +: PW] = pix(base, r - (NL-1) + wr, c - (NL-1) + wc);
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input int base, input int w, input int h, input bit gaps,
                              input int bad_r, input int bad_c,
                              input int stall_r, input int stall_c, input int abort_r);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == abort_r && c == 2) begin
                    @(negedge clk); in_valid = 0; rst = 1;
                    @(negedge clk); rst = 0;
                    return;
                end
                if (r == stall_r && c == stall_c) begin
                    @(negedge clk); clken = 0; in_valid = 1; col_data = '1;
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clk);
                        chk("stall_valid", win_valid, 1);
                        chk("stall_busy", busy, 1);
                    end
                    clken = 1; in_valid = 0;
                end
                if (gaps && (c % 3 == 1)) begin
                    @(negedge clk); in_valid = 0;
                end
                send_col(base, r, c, (r == bad_r && c == bad_c) ? 5'b01111 : 5'b11111);
            end
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", (n < 200), 1);
    endtask

    task automatic check_frame(input int exp_w, input int base);
        chk("win_count", win_cnt, exp_w);
        chk("fd_count", fd_cnt, 1);
        chk("sb_empty", sb.size(), 0);
        chk("first_x", f_x, 2);
        chk("first_y", f_y, 2);
        chk("first_00", f_00, pix(base, 0, 0));
        chk("first_44", f_44, pix(base, 4, 4));
        chk("done_not_busy", busy, 0);
        win_cnt = 0; fd_cnt = 0; got_first = 0;
    endtask

    initial begin
        rst = 1; clken = 1; start = 0; in_valid = 0;
        width = '0; height = '0; col_data = '0; line_valid = '1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_data", win_data, 0);
        chk("rst_win_x", win_x, 0);
        chk("rst_win_y", win_y, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);

        // Plain 8x6 frame, columns back-to-back.
        do_start(8, 6);
        chk("fill_busy", busy, 1);
        send_frame(16'h000, 8, 6, 0, -1, -1, -1, -1, -1);
        wait_done();
        check_frame(8, 16'h000);
        chk("f1_err", err, 0);

        // Same frame with in_valid gaps and a clken stall mid-row.
        do_start(8, 6);
        send_frame(16'h100, 8, 6, 1, -1, -1, 4, 6, -1);
        wait_done();
        check_frame(8, 16'h100);

        // Undersized start is rejected.
        @(negedge clk); start = 1; width = 4; height = 6;
        @(negedge clk); start = 0;
        chk("bad_start_err", err, 1);
        chk("bad_start_busy", busy, 0);
        @(negedge clk);
        chk("bad_start_idle", busy, 0);

        // Valid start clears err; bad line_valid in RUN sets it again.
        do_start(8, 6);
        chk("start_clears_err", err, 0);
        send_frame(16'h200, 8, 6, 0, 5, 3, -1, -1, -1);
        wait_done();
        chk("lv_err_sticky", err, 1);
        check_frame(8, 16'h200);

        // Reset during row 3 aborts the frame.
        do_start(8, 6);
        chk("start2_clears_err", err, 0);
        send_frame(16'h300, 8, 6, 0, -1, -1, -1, -1, 3);
        chk("abort_win_valid", win_valid, 0);
        chk("abort_win_data", win_data, 0);
        chk("abort_win_x", win_x, 0);
        chk("abort_win_y", win_y, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 0);
        chk("abort_fd", frame_done, 0);
        chk("abort_no_wins", win_cnt + sb.size(), 0);
        chk("abort_no_done", fd_cnt, 0);
        win_cnt = 0; fd_cnt = 0; got_first = 0;

        do_start(8, 6);
        send_frame(16'h040, 8, 6, 0, -1, -1, -1, -1, -1);
        wait_done();
        check_frame(8, 16'h040);

        // Back-to-back: start on the cycle after frame_done.
        do_start(8, 6);
        send_frame(16'h180, 8, 6, 0, -1, -1, -1, -1, -1);
        wait_done();
        check_frame(8, 16'h180);

        // Minimum 5x5 frame yields a single window.
        do_start(5, 5);
        send_frame(16'h2A0, 5, 5, 0, -1, -1, -1, -1, -1);
        wait_done();
        check_frame(1, 16'h2A0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_window_reader.md
LINE_WINDOW_READER -- requirements
Module: line_window_reader

Interface
REQ-001 Parameter NUM_LINE, default 5: window height and width in pixels.
REQ-002 Parameter PWIDTH, default 14: bits per pixel.
REQ-003 Parameter AWIDTH, default 11: width of the column and row counters.
REQ-004 clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clken  input  1  clock enable; low freezes all state.
REQ-007 start  input  1  one-cycle pulse that begins a frame; accepted only in IDLE.
REQ-008 width  input  AWIDTH  image width in pixels; latched on start.
REQ-009 height  input  AWIDTH  image height in pixels; latched on start.
REQ-010 in_valid  input  1  col_data carries one new column this cycle.
REQ-011 col_data  input  NUM_LINE*PWIDTH  one column from the line-buffer read ports; slice r (bits r*PWIDTH upward) is row r; r=0 is the oldest row.
REQ-012 line_valid  input  NUM_LINE  per-line valid flags from the line-buffer controller.
REQ-013 win_valid  output  1  win_data, win_x and win_y hold a new window.
REQ-014 win_data  output  NUM_LINE*NUM_LINE*PWIDTH  the window; element [r][c] sits at bit (r*NUM_LINE+c)*PWIDTH; c=0 is the oldest column.
REQ-015 win_x, win_y  output  AWIDTH each  image coordinates of the window centre.
REQ-016 frame_done  output  1  one-cycle pulse after the last column of a frame is accepted.
REQ-017 err  output  1  sticky error flag; cleared only by reset or by an accepted start.
REQ-018 busy  output  1  high in FILL and RUN.

Function
REQ-019 The state machine SHALL have four states: IDLE, FILL, RUN and DONE.
- IDLE->FILL on an accepted start.
- FILL->RUN when the column counter wraps at the end of row NUM_LINE-2.
- RUN->DONE on acceptance of column width-1 of row height-1.
- DONE->IDLE unconditionally on the next enabled cycle.
REQ-020 A start SHALL be rejected, with err set and the state left at IDLE, if width<NUM_LINE or height<NUM_LINE.
REQ-021 A column SHALL be accepted only when clken=1, in_valid=1 and the state is FILL or RUN; in_valid in IDLE or DONE SHALL be ignored.
REQ-022 Each accepted column SHALL shift into a NUM_LINE-deep column register.
- col_cnt counts 0..width-1 and wraps to 0.
- row_cnt increments on each wrap.
REQ-023 win_valid SHALL assert exactly one cycle after an accepted column with col_cnt>=NUM_LINE-1 and row_cnt>=NUM_LINE-1.
- Windows are interior-only: no border replication.
- Each frame yields (width-NUM_LINE+1)*(height-NUM_LINE+1) windows.
REQ-024 win_x SHALL equal col_cnt-(NUM_LINE-1)/2 and win_y SHALL equal row_cnt-(NUM_LINE-1)/2, both taken from the triggering column.
REQ-025 Columns left over from the previous row SHALL never contribute to a window; the col_cnt gating in REQ-023 guarantees this.
REQ-026 In RUN, an accepted column with line_valid not all ones SHALL set err; processing continues unchanged.
REQ-027 frame_done SHALL pulse in the cycle the state is DONE.
REQ-028 With clken=0, every register, all outputs included, SHALL hold; win_valid therefore holds its value and downstream logic qualifies it with clken.
REQ-029 A start received outside IDLE SHALL be ignored.
REQ-030 Counter wrap and the RUN->DONE transition occurring on the same column SHALL also emit the final window that column triggers.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL enter IDLE, and the following SHALL be reset:
- cleared: counters, column register, latched width and height.
- driven low: win_valid, frame_done, err, busy.
- zeroed: win_data, win_x, win_y.
REQ-032 rst SHALL override clken; reset mid-frame SHALL abort the frame with no frame_done.

Structure
REQ-033 A shared package SHALL hold:
- the NUM_LINE, PWIDTH and AWIDTH defaults;
- the state enumeration;
- the window element index helper.
REQ-034 The column shift register SHALL be a sub-module named window_shift_reg, parameterised by NUM_LINE and PWIDTH, with shift-enable and parallel window output.

Verification
REQ-035 width=8, height=6, pixel(r,c)=r*16+c, all columns back-to-back.
- Exactly 8 windows.
- First window: win_x=2, win_y=2, element [0][0]=0x00 and [4][4]=0x44, one cycle after row 4, column 4 is accepted.
- frame_done pulses once.
REQ-036 Repeat REQ-035 with clken low for 3 cycles mid-row and in_valid gaps.
- Window sequence and contents are identical.
- Outputs hold during the stall.
REQ-037 start with width=4 -> err=1, state stays IDLE, busy=0; a later valid start clears err.
REQ-038 line_valid=5'b01111 on one column in RUN -> err=1 and stays set; window count unchanged.
REQ-039 rst=1 for one cycle during row 3 -> IDLE and all outputs zero; a new start then completes a full frame correctly.
REQ-040 Two frames back-to-back, start issued the cycle after frame_done -> the second frame's windows are correct and uncontaminated by first-frame columns.
